mp_add_seq: RTL and testbench

MP_ADD_SEQ -- requirements
Module: mp_add_seq

---
 rtl/mp_add_seq_pkg.sv | 18 +
 rtl/CLA8bit.sv | 44 ++++
 rtl/mp_add_seq.sv | 143 ++++++++++++++
 tb/tb_mp_add_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mp_add_seq_pkg.sv
// Shared constants and types for the multi-precision sequential adder.
// The package holds the limb width, the FSM encoding and the signed-overflow rule.
package mp_add_seq_pkg;

  localparam int LIMB_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: both addends share a sign and the sum's sign differs from it.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/CLA8bit.sv
// 8-bit carry-lookahead adder: every carry is a flat sum of generate/propagate products,
// so no carry signal depends on another carry.
module CLA8bit
  import mp_add_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  logic [LIMB_W-1:0] g_s;
  logic [LIMB_W-1:0] p_s;
  logic [LIMB_W:0]   c_s;

  // Lookahead carries plus the sum bits.
  always_comb begin
    logic acc;
    logic term;
    g_s    = a & b;
    p_s    = a ^ b;
    c_s    = '0;
    c_s[0] = cin;
    for (int i = 0; i < LIMB_W; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g_s[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p_s[m];
        end
        acc = acc | term;
      end
      term = cin;
      for (int m = 0; m <= i; m++) begin
        term = term & p_s[m];
      end
      c_s[i+1] = acc | term;
    end
    sum  = p_s ^ c_s[LIMB_W-1:0];
    cout = c_s[LIMB_W];
  end

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision add/subtract: one shared 8-bit CLA walks the operands
// LSB limb first, one limb per cycle, then holds the result until handshaked.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LIMB_W*NBYTES-1:0]   op_a,
  input  logic [LIMB_W*NBYTES-1:0]   op_b,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LIMB_W*NBYTES-1:0]   result,
  output logic                       carry_out,
  output logic                       overflow
);

  localparam int W  = LIMB_W * NBYTES;
  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  state_t              state_r;
  state_t              state_s;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        result_r;
  logic                sub_r;
  logic                carry_r;
  logic                carry_out_r;
  logic                overflow_r;
  logic [KW-1:0]       k_r;
  logic [LIMB_W-1:0]   a_byte_s;
  logic [LIMB_W-1:0]   b_byte_s;
  logic [LIMB_W-1:0]   sum_s;
  logic                cout_s;
  logic                last_s;

  // Limb selection; B is inverted for subtraction, the +1 arrives via the carry register.
  always_comb begin
    a_byte_s = a_r[LIMB_W*int'(k_r) +: LIMB_W];
    b_byte_s = b_r[LIMB_W*int'(k_r) +: LIMB_W] ^ {LIMB_W{sub_r}};
    last_s   = (k_r == K_LAST);
  end

  CLA8bit u_cla (
    .a    (a_byte_s),
    .b    (b_byte_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture and limb-serial datapath; results hold outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      sub_r       <= 1'b0;
      carry_r     <= 1'b0;
      k_r         <= '0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= op_a;
            b_r     <= op_b;
            sub_r   <= sub;
            carry_r <= sub;
            k_r     <= '0;
          end
        end
        RUN: begin
          result_r[LIMB_W*int'(k_r) +: LIMB_W] <= sum_s;
          carry_r <= cout_s;
          if (last_s) begin
            k_r         <= '0;
            carry_out_r <= cout_s;
            overflow_r  <= add_overflow(a_byte_s[LIMB_W-1], b_byte_s[LIMB_W-1], sum_s[LIMB_W-1]);
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq (NBYTES=4): the driver queues hand-computed
// expectations, a negedge monitor pops and compares on every result handshake.
module tb_mp_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  mp_add_seq #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%08h expected none", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
        chk("overflow", {31'd0, overflow}, {31'd0, e.o});
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic ec, input logic eo,
                        input bit scramble, input bit stall, input bit chk_lat);
    int n;
    int cyc;
    exp_t e;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_req", {31'd0, in_ready}, 32'd1);
    op_a      = a;
    op_b      = b;
    sub       = s;
    in_valid  = 1'b1;
    out_ready = !stall;
    e.r = er;
    e.c = ec;
    e.o = eo;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      if (scramble) begin
        op_a = $urandom;
        op_b = $urandom;
        sub  = ~sub;
      end
      tick();
      cyc++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    if (chk_lat) chk("latency_cycles", 32'(cyc), 32'd5);
    if (stall) begin
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        op_a     = 32'h0BAD_F00D;
        op_b     = 32'h1234_0000;
        chk("stall_result", result, er);
        chk("stall_carry", {31'd0, carry_out}, {31'd0, ec});
        chk("stall_ovf", {31'd0, overflow}, {31'd0, eo});
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
      end
      chk("stall_still_valid", {31'd0, out_valid}, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
      chk("valid_after_hs", {31'd0, out_valid}, 32'd0);
    end else begin
      tick();
    end
  endtask

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_req(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_req(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_req(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_req(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_req(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_req(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_req(32'h89AB_CDEF, 32'h7654_3210, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_req(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Abort an operation in its second RUN cycle; nothing may be emitted.
    op_a     = 32'h0000_00AA;
    op_b     = 32'h0000_0011;
    sub      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_req(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("idle_no_result", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
